// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment receive path.
//   state_t    : settle FSM states
//   err_code_t : encodings reported on sseg_rx.err_code
//   SEG_LUT    : active-high {g,f,e,d,c,b,a} pattern for each hex digit,
//                index = digit value (same table as the hex2sseg driver)
package sseg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HELD
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_MULTI   = 2'd1,
    ERR_DECODE  = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/sseg2hex.sv
// Combinational seven-segment pattern decoder.
//   pattern in  7  active-high segments {g,f,e,d,c,b,a}
//   hit     out 1  pattern matches one of the 16 hex glyphs
//   hex     out 4  decoded digit (0 when hit is low)
module sseg2hex
  import sseg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       hit,
  output logic [3:0] hex
);

  always_comb begin
    hit = 1'b0;
    hex = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (!hit && pattern == SEG_LUT[i]) begin
        hit = 1'b1;
        hex = 4'(i);
      end
    end
  end

endmodule

// File: rtl/sseg_rx.sv
// Receive-side monitor for a 4-digit multiplexed seven-segment display.
// Synchronises the anode/cathode lines, waits for each anode slot to hold
// a steady pattern, decodes it back to hex and tracks per-slot validity,
// frame completion and illegal line states.
//   clk, rst      clock, asynchronous active-high reset
//   enabled       sample strobe; FSM and counters move only when high
//   sseg_an[3:0]  anode lines (async), bit N selects digit N
//   sseg_ca[6:0]  cathode lines (async) {g,f,e,d,c,b,a}
//   digit0..3     last decoded hex per slot
//   digit_valid   per-slot capture newer than last timeout/reset
//   frame_done    1-cycle pulse once all four slots captured
//   err, err_code 1-cycle pulse + reason (1 multi-anode, 2 undecodable, 3 timeout)
module sseg_rx
  import sseg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  parameter bit          CA_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enabled,
  input  logic [3:0] sseg_an,
  input  logic [6:0] sseg_ca,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] digit_valid,
  output logic       frame_done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STABLE_MAX  = SW'(STABLE_CYCLES);
  localparam logic [SW-1:0] CNT_ONE     = SW'(1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [3:0]    AN_OFF      = AN_ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [6:0]    CA_OFF      = CA_ACTIVE_LOW ? 7'h7F : 7'h00;

  // Synchroniser resets to the inactive line level so the first samples
  // after reset read as "no anode" rather than "all anodes".
  logic [3:0] an_meta, an_sync;
  logic [6:0] ca_meta, ca_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_meta <= AN_OFF;
      an_sync <= AN_OFF;
      ca_meta <= CA_OFF;
      ca_sync <= CA_OFF;
    end else begin
      an_meta <= sseg_an;
      an_sync <= an_meta;
      ca_meta <= sseg_ca;
      ca_sync <= ca_meta;
    end
  end

  logic [3:0] an_n;
  logic [6:0] ca_n;
  assign an_n = AN_ACTIVE_LOW ? ~an_sync : an_sync;
  assign ca_n = CA_ACTIVE_LOW ? ~ca_sync : ca_sync;

  // Settle FSM
  state_t        state, state_nx;
  logic [SW-1:0] cnt, cnt_nx, cnt_inc;
  logic [3:0]    prev_an;
  logic [6:0]    prev_ca;
  logic          multi, none, same, capture, err_multi;

  assign cnt_inc = cnt + CNT_ONE;
  assign multi   = (an_n & (an_n - 4'd1)) != 4'd0;
  assign none    = (an_n == 4'd0);
  assign same    = (an_n == prev_an) && (ca_n == prev_ca);

  // The sample that brings the count to STABLE_CYCLES is the capture
  // sample; a fresh dwell starts counting at 1 on its first sample.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    capture   = 1'b0;
    err_multi = 1'b0;
    if (enabled) begin
      if (multi) begin
        err_multi = 1'b1;
        state_nx  = IDLE;
        cnt_nx    = '0;
      end else if (none) begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end else if (state != IDLE && same) begin
        if (state == SETTLE) begin
          cnt_nx = cnt_inc;
          if (cnt_inc >= STABLE_MAX) begin
            capture  = 1'b1;
            state_nx = HELD;
          end
        end
      end else begin
        cnt_nx = CNT_ONE;
        if (CNT_ONE >= STABLE_MAX) begin
          capture  = 1'b1;
          state_nx = HELD;
        end else begin
          state_nx = SETTLE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      prev_an <= '0;
      prev_ca <= '0;
    end else if (enabled) begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      prev_an <= an_n;
      prev_ca <= ca_n;
    end
  end

  // Decode and slot select
  logic       hit;
  logic [3:0] hex;
  logic [1:0] slot;

  sseg2hex u_dec (
    .pattern (ca_n),
    .hit     (hit),
    .hex     (hex)
  );

  always_comb begin
    slot = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (an_n[i]) slot = 2'(i);
    end
  end

  logic          cap_ok, cap_bad, t_fire, t_armed;
  logic [TW-1:0] tcnt, tcnt_inc;
  logic [3:0]    digit_q [4];
  logic [3:0]    valid_q, mask;

  assign cap_ok   = capture & hit;
  assign cap_bad  = capture & ~hit;
  assign tcnt_inc = tcnt + TW'(1);
  // A successful capture in the expiry sample pre-empts the timeout.
  assign t_fire   = enabled && t_armed && !cap_ok && (tcnt_inc >= TIMEOUT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q    <= '{default: '0};
      valid_q    <= '0;
      mask       <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      tcnt       <= '0;
      t_armed    <= 1'b1;
    end else begin
      // mask==F lives exactly one cycle, so frame_done is a single pulse.
      frame_done <= (mask == 4'hF);
      err        <= t_fire | cap_bad | err_multi;
      if (t_fire)         err_code <= ERR_TIMEOUT;
      else if (cap_bad)   err_code <= ERR_DECODE;
      else if (err_multi) err_code <= ERR_MULTI;
      else                err_code <= ERR_NONE;

      if (cap_ok) digit_q[slot] <= hex;

      if (t_fire) begin
        valid_q <= '0;
        mask    <= '0;
      end else begin
        if (cap_ok) valid_q <= valid_q | an_n;
        mask <= ((mask == 4'hF) ? 4'h0 : mask) | (cap_ok ? an_n : 4'h0);
      end

      // Disarmed after firing; only a capture re-arms the timeout.
      if (cap_ok) begin
        tcnt    <= '0;
        t_armed <= 1'b1;
      end else if (enabled && t_armed) begin
        if (tcnt != TIMEOUT_MAX) tcnt <= tcnt_inc;
        if (t_fire) t_armed <= 1'b0;
      end
    end
  end

  assign digit0      = digit_q[0];
  assign digit1      = digit_q[1];
  assign digit2      = digit_q[2];
  assign digit3      = digit_q[3];
  assign digit_valid = valid_q;

endmodule

// File: tb/tb_sseg_rx.sv
// Self-checking bench for sseg_rx: directed scenarios plus randomized
// dwell sequences scored against a slot/frame reference model.
module tb_sseg_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       enabled;
  logic [3:0] sseg_an;
  logic [6:0] sseg_ca;
  logic [3:0] digit0, digit1, digit2, digit3, digit_valid;
  logic       frame_done, err;
  logic [1:0] err_code;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned frames  = 0;
  int unsigned errs [4] = '{0, 0, 0, 0};
  int unsigned f_snap;
  int unsigned e_snap [4];

  // Reference glyphs, active-high {g..a}, indexed by hex value.
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  always #5 clk = ~clk;

  sseg_rx #(
    .STABLE_CYCLES  (4),
    .TIMEOUT_CYCLES (1024),
    .AN_ACTIVE_LOW  (1'b1),
    .CA_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enabled     (enabled),
    .sseg_an     (sseg_an),
    .sseg_ca     (sseg_ca),
    .digit0      (digit0),
    .digit1      (digit1),
    .digit2      (digit2),
    .digit3      (digit3),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .err         (err),
    .err_code    (err_code)
  );

  // Pulses last a full clock, so each is seen exactly once at negedge.
  always @(negedge clk) begin
    if (frame_done) frames++;
    if (err) errs[err_code]++;
  end

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic drive(input int unsigned slot, input logic [6:0] seg_hi);
    sseg_an = ~(4'b0001 << slot);
    sseg_ca = ~seg_hi;
  endtask

  task automatic blank();
    sseg_an = 4'hF;
    sseg_ca = 7'h7F;
  endtask

  task automatic snap();
    f_snap = frames;
    for (int i = 0; i < 4; i++) e_snap[i] = errs[i];
  endtask

  // Reference model state for the random phase
  int unsigned m_digit [4];
  logic [3:0]  m_valid, m_mask;
  int unsigned m_frames, m_err2;

  initial begin
    logic [3:0] t2_vals [4];
    logic [3:0] t5_vals [4];
    t2_vals = '{4'h1, 4'h2, 4'h3, 4'hA};
    t5_vals = '{4'h4, 4'h5, 4'h6, 4'h7};

    rst = 1'b1; enabled = 1'b0; blank();
    tick(3);
    check_eq("rst_digits", {digit3, digit2, digit1, digit0}, 0);
    check_eq("rst_valid", digit_valid, 0);
    check_eq("rst_frame", frame_done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_code", err_code, 0);
    rst = 1'b0; enabled = 1'b1;
    tick(2);

    // 1: digit "0" on slot 0; capture lands on the 6th edge
    snap();
    drive(0, GLYPH[0]);
    tick(5);
    check_eq("t1_valid_early", digit_valid, 4'b0000);
    tick(1);
    check_eq("t1_valid", digit_valid, 4'b0001);
    check_eq("t1_digit0", digit0, 0);
    tick(2);
    check_eq("t1_no_err", errs[1] + errs[2] + errs[3] - e_snap[1] - e_snap[2] - e_snap[3], 0);

    // 2: full frame 1,2,3,A
    snap();
    for (int s = 0; s < 4; s++) begin
      drive(s, GLYPH[t2_vals[s]]);
      tick(8);
    end
    tick(2);
    check_eq("t2_digits", {digit3, digit2, digit1, digit0}, 16'hA321);
    check_eq("t2_valid", digit_valid, 4'hF);
    check_eq("t2_frames", frames - f_snap, 1);
    check_eq("t2_no_err", errs[1] + errs[2] + errs[3] - e_snap[1] - e_snap[2] - e_snap[3], 0);

    // 3: unstable pattern on slot 1 never captures
    snap();
    for (int k = 0; k < 8; k++) begin
      drive(1, GLYPH[(k % 2 == 1) ? 5 : 6]);
      tick(2);
    end
    blank();
    tick(4);
    check_eq("t3_digit1", digit1, 4'h2);
    check_eq("t3_frames", frames - f_snap, 0);

    // 4: multiple anodes, then undecodable blank on slot 2
    snap();
    sseg_an = 4'b1100;
    sseg_ca = ~GLYPH[0];
    tick(4);
    check_eq("t4_multi_seen", (errs[1] > e_snap[1]) ? 1 : 0, 1);
    blank();
    tick(3);
    drive(2, 7'h00);
    tick(8);
    check_eq("t4_decode_err", errs[2] - e_snap[2], 1);
    check_eq("t4_valid2", digit_valid[2], 1);
    check_eq("t4_digit2", digit2, 4'h3);

    // 5: recapture all slots, then let the timeout expire
    snap();
    for (int s = 0; s < 4; s++) begin
      drive(s, GLYPH[t5_vals[s]]);
      tick(8);
    end
    blank();
    tick(1000);
    check_eq("t5_valid_before_to", digit_valid, 4'hF);
    check_eq("t5_no_early_to", errs[3] - e_snap[3], 0);
    tick(100);
    check_eq("t5_valid_after_to", digit_valid, 4'h0);
    check_eq("t5_one_to", errs[3] - e_snap[3], 1);
    check_eq("t5_digits_kept", {digit3, digit2, digit1, digit0}, 16'h7654);
    check_eq("t5_frames", frames - f_snap, 1);

    // 6: enabled-low cycles do not advance settle; reset mid-dwell
    drive(0, GLYPH[9]);
    enabled = 1'b0;
    tick(20);
    enabled = 1'b1;
    tick(3);
    check_eq("t6_no_capture_valid", digit_valid, 0);
    check_eq("t6_no_capture_digit0", digit0, 4'h4);
    rst = 1'b1;
    blank();
    #1;
    check_eq("t6_rst_digits", {digit3, digit2, digit1, digit0}, 0);
    check_eq("t6_rst_err", {err, err_code}, 0);
    tick(2);
    rst = 1'b0;
    tick(8);
    check_eq("t6_post_valid", digit_valid, 0);
    check_eq("t6_post_frame", frame_done, 0);

    // Random dwells scored against the slot/frame model
    snap();
    m_digit = '{0, 0, 0, 0};
    m_valid = '0; m_mask = '0; m_frames = 0; m_err2 = 0;
    for (int d = 0; d < 60; d++) begin
      int unsigned slot, hx, len;
      logic        bad;
      slot = $urandom_range(0, 3);
      hx   = $urandom_range(0, 15);
      len  = $urandom_range(1, 7);
      bad  = ($urandom_range(0, 9) == 0);
      drive(slot, bad ? 7'h00 : GLYPH[hx]);
      tick(len);
      blank();
      tick(2);
      if (len >= 4) begin
        if (bad) m_err2++;
        else begin
          m_digit[slot] = hx;
          m_valid[slot] = 1'b1;
          m_mask[slot]  = 1'b1;
          if (m_mask == 4'hF) begin
            m_frames++;
            m_mask = '0;
          end
        end
      end
    end
    tick(6);
    check_eq("rnd_digit0", digit0, m_digit[0]);
    check_eq("rnd_digit1", digit1, m_digit[1]);
    check_eq("rnd_digit2", digit2, m_digit[2]);
    check_eq("rnd_digit3", digit3, m_digit[3]);
    check_eq("rnd_valid", digit_valid, m_valid);
    check_eq("rnd_frames", frames - f_snap, m_frames);
    check_eq("rnd_decode_errs", errs[2] - e_snap[2], m_err2);
    check_eq("rnd_other_errs", errs[1] + errs[3] - e_snap[1] - e_snap[3], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
